// File: rtl/wb_write_arbiter_pkg.sv
// rtl/wb_write_arbiter_pkg.sv - shared widths, defaults and entry type for the write-port arbiter
package wb_write_arbiter_pkg;

  localparam int RegAddrWidth = 5;
  localparam int RegWidth     = 32;
  localparam int WbArbDepth   = 2;
  localparam int WbArbMaxWait = 8;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegWidth-1:0]     data;
  } cop_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [RegAddrWidth-1:0] addr);
    logic [31:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_cop_fifo.sv
// rtl/wb_cop_fifo.sv - synchronous coprocessor result FIFO with per-entry valid/addr visibility
module wb_cop_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WbArbDepth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [RegAddrWidth-1:0]       push_addr,
  input  logic [RegWidth-1:0]           push_data,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [RegAddrWidth-1:0]       head_addr,
  output logic [RegWidth-1:0]           head_data,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [DEPTH*RegAddrWidth-1:0] entry_addr
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  cop_entry_t       mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PtrW-1:0]  head_q;
  logic [PtrW-1:0]  tail_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_q] <= '{addr: push_addr, data: push_data};
    end
  end

  assign head_addr   = mem[head_q].addr;
  assign head_data   = mem[head_q].data;
  assign entry_valid = valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_addr
    assign entry_addr[i*RegAddrWidth +: RegAddrWidth] = mem[i].addr;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write port shared by write-back and AES coprocessor
// Optional starvation guard: WBARB_STARVE_EN
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WbArbDepth,
  parameter int MAX_WAIT   = WbArbMaxWait
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_w_enable_i,
  input  logic [RegAddrWidth-1:0] wb_w_addr_i,
  input  logic [RegWidth-1:0]     wb_w_data_i,
  input  logic                    cop_req_i,
  input  logic [RegAddrWidth-1:0] cop_addr_i,
  input  logic [RegWidth-1:0]     cop_data_i,
  output logic                    cop_ready_o,
  output logic                    stall_o,
  output logic [31:0]             pend_mask_o,
  output logic                    w_enable_o,
  output logic [RegAddrWidth-1:0] w_addr_o,
  output logic [RegWidth-1:0]     w_data_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_param
    $error("wb_write_arbiter: FIFO_DEPTH must be a power of two >= 2 and MAX_WAIT >= 1");
  end

  logic                               full;
  logic                               empty;
  logic                               push;
  logic                               pop;
  logic                               slot_busy;
  logic [RegAddrWidth-1:0]            head_addr;
  logic [RegWidth-1:0]                head_data;
  logic [FIFO_DEPTH-1:0]              entry_valid;
  logic [FIFO_DEPTH*RegAddrWidth-1:0] entry_addr;
  logic [31:0]                        pend;

  // Writes to x0 complete the handshake but are never queued.
  assign cop_ready_o = !rst && !full;
  assign push        = cop_req_i && cop_ready_o && (cop_addr_i != '0);

`ifdef WBARB_STARVE_EN
  localparam int WaitW = $clog2(MAX_WAIT + 1);
  logic [WaitW-1:0] wait_q;

  assign stall_o = !rst && (wait_q == WaitW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst || pop || empty) begin
      wait_q <= '0;
    end else if (wait_q != WaitW'(MAX_WAIT)) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`else
  assign stall_o = 1'b0;
`endif

  // A stalled pipeline slot counts as free, which is how the guard forces a pop.
  assign slot_busy = wb_w_enable_i && (wb_w_addr_i != '0) && !stall_o;
  assign pop       = !rst && !empty && !slot_busy;

  wb_cop_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (cop_addr_i),
    .push_data   (cop_data_i),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_comb begin
    w_enable_o = 1'b0;
    w_addr_o   = '0;
    w_data_o   = '0;
    if (!rst && slot_busy) begin
      w_enable_o = 1'b1;
      w_addr_o   = wb_w_addr_i;
      w_data_o   = wb_w_data_i;
    end else if (pop) begin
      w_enable_o = 1'b1;
      w_addr_o   = head_addr;
      w_data_o   = head_data;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        pend = pend | reg_onehot(entry_addr[i*RegAddrWidth +: RegAddrWidth]);
      end
    end
  end

  assign pend_mask_o = rst ? 32'h0 : (pend & ~32'h1);

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - self-checking bench with a queue-level model of the arbiter
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXW  = 8;
`ifdef WBARB_STARVE_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_w_enable_i;
  logic [4:0]  wb_w_addr_i;
  logic [31:0] wb_w_data_i;
  logic        cop_req_i;
  logic [4:0]  cop_addr_i;
  logic [31:0] cop_data_i;
  logic        cop_ready_o;
  logic        stall_o;
  logic [31:0] pend_mask_o;
  logic        w_enable_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_w_enable_i (wb_w_enable_i),
    .wb_w_addr_i   (wb_w_addr_i),
    .wb_w_data_i   (wb_w_data_i),
    .cop_req_i     (cop_req_i),
    .cop_addr_i    (cop_addr_i),
    .cop_data_i    (cop_data_i),
    .cop_ready_o   (cop_ready_o),
    .stall_o       (stall_o),
    .pend_mask_o   (pend_mask_o),
    .w_enable_o    (w_enable_o),
    .w_addr_o      (w_addr_o),
    .w_data_o      (w_data_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: the queue as a list of pending writes plus a wait age.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];
  int   mwait = 0;

  always @(negedge clk) begin
    logic        e_rdy, e_stall, e_we, busy, popd, pushd, was_empty;
    logic [4:0]  e_a;
    logic [31:0] e_d, e_p;
    e_rdy   = !rst && (mq.size() < DEPTH);
    e_stall = GUARD && !rst && (mq.size() > 0) && (mwait >= MAXW);
    e_p     = '0;
    if (!rst) foreach (mq[i]) e_p[mq[i].a] = 1'b1;
    busy = wb_w_enable_i && (wb_w_addr_i != 0) && !e_stall;
    popd = 1'b0;
    e_we = 1'b0;
    e_a  = '0;
    e_d  = '0;
    if (!rst && busy) begin
      e_we = 1'b1; e_a = wb_w_addr_i; e_d = wb_w_data_i;
    end else if (!rst && mq.size() > 0) begin
      e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d; popd = 1'b1;
    end
    check("m_ready", cop_ready_o, e_rdy);
    check("m_stall", stall_o, e_stall);
    check("m_pend", pend_mask_o, e_p);
    check("m_we", w_enable_o, e_we);
    if (e_we || rst) begin
      check("m_waddr", w_addr_o, e_a);
      check("m_wdata", w_data_o, e_d);
    end
    pushd = cop_req_i && e_rdy && (cop_addr_i != 0);
    if (rst) begin
      mq.delete();
      mwait = 0;
    end else begin
      was_empty = (mq.size() == 0);
      if (popd) void'(mq.pop_front());
      if (pushd) mq.push_back('{a: cop_addr_i, d: cop_data_i});
      if (was_empty || popd) mwait = 0;
      else if (mwait < MAXW) mwait++;
    end
  end

  logic       last_stall = 1'b0;
  int         stall_cnt  = 0;
  logic [4:0] stall_addr = '0;

  task automatic mid();
    @(negedge clk);
    last_stall = stall_o;
    if (stall_o) begin
      stall_cnt++;
      stall_addr = w_addr_o;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_w_enable_i = 1'b0; wb_w_addr_i = '0; wb_w_data_i = '0;
    cop_req_i = 1'b0; cop_addr_i = '0; cop_data_i = '0;
    mid();
    check("rst_ready", cop_ready_o, 1'b0);
    check("rst_we", w_enable_o, 1'b0);
    check("rst_pend", pend_mask_o, 32'h0);
    check("rst_stall", stall_o, 1'b0);
    adv(); mid(); adv();
    rst = 1'b0;

    // single push to x5 lands next cycle
    cop_req_i = 1'b1; cop_addr_i = 5'd5; cop_data_i = 32'hDEADBEEF;
    mid();
    check("t1_ready", cop_ready_o, 1'b1);
    adv();
    cop_req_i = 1'b0;
    mid();
    check("t1_we", w_enable_o, 1'b1);
    check("t1_addr", w_addr_o, 5'd5);
    check("t1_data", w_data_o, 32'hDEADBEEF);
    check("t1_pend", pend_mask_o, 32'h20);
    adv(); mid();
    check("t1_pend_clr", pend_mask_o, 32'h0);
    check("t1_we_clr", w_enable_o, 1'b0);
    adv();

    // pipeline hogs the port while x7, x8 queue up
    stall_cnt = 0;
    wb_w_enable_i = 1'b1; wb_w_addr_i = 5'd1; wb_w_data_i = 32'h1000;
    for (int i = 0; i < 14; i++) begin
      cop_req_i = (i < 3);
      cop_addr_i = (i == 0) ? 5'd7 : (i == 1) ? 5'd8 : 5'd9;
      cop_data_i = (i == 0) ? 32'h77 : (i == 1) ? 32'h88 : 32'h99;
      mid();
      if (i < 2) check("t2_ready_open", cop_ready_o, 1'b1);
      if (i == 2) check("t2_ready_full", cop_ready_o, 1'b0);
      if (i == 5) check("t2_pend", pend_mask_o, 32'h180);
      if (GUARD && i == 10) begin
        check("t2_held_addr", w_addr_o, 5'd1);
        check("t2_held_data", w_data_o, 32'h1009);
      end
      adv();
      if (!last_stall) wb_w_data_i = wb_w_data_i + 1;
    end
    wb_w_enable_i = 1'b0; cop_req_i = 1'b0;
    check("t2_stall_cnt", stall_cnt, GUARD ? 1 : 0);
    if (GUARD) check("t2_forced_addr", stall_addr, 5'd7);
    mid();
    check("t2_free0_addr", w_addr_o, GUARD ? 5'd8 : 5'd7);
    check("t2_free0_data", w_data_o, GUARD ? 32'h88 : 32'h77);
    adv(); mid();
    check("t2_free1_we", w_enable_o, !GUARD);
    if (!GUARD) check("t2_free1_addr", w_addr_o, 5'd8);
    adv();

    // x0 push is accepted and dropped
    cop_req_i = 1'b1; cop_addr_i = 5'd0; cop_data_i = 32'h1234;
    mid();
    check("t3_ready", cop_ready_o, 1'b1);
    adv();
    cop_req_i = 1'b0;
    mid();
    check("t3_pend", pend_mask_o, 32'h0);
    check("t3_we", w_enable_o, 1'b0);
    adv();

    // full queue: pop frees space but the same-cycle push is refused
    wb_w_enable_i = 1'b1; wb_w_addr_i = 5'd1; wb_w_data_i = 32'h2000;
    for (int i = 0; i < 2; i++) begin
      cop_req_i = 1'b1; cop_addr_i = (i == 0) ? 5'd10 : 5'd11; cop_data_i = (i == 0) ? 32'hA0 : 32'hB0;
      mid(); adv();
    end
    wb_w_enable_i = 1'b0;
    cop_addr_i = 5'd12; cop_data_i = 32'hC0;
    mid();
    check("t4_ready_full", cop_ready_o, 1'b0);
    check("t4_pop_a", w_addr_o, 5'd10);
    adv(); mid();
    check("t4_ready_next", cop_ready_o, 1'b1);
    check("t4_pop_b", w_addr_o, 5'd11);
    adv();
    cop_req_i = 1'b0;
    mid();
    check("t4_pop_c", w_addr_o, 5'd12);
    check("t4_data_c", w_data_o, 32'hC0);
    adv(); mid(); adv();

    // reset with two queued entries discards them
    wb_w_enable_i = 1'b1; wb_w_addr_i = 5'd1; wb_w_data_i = 32'h3000;
    for (int i = 0; i < 2; i++) begin
      cop_req_i = 1'b1; cop_addr_i = (i == 0) ? 5'd13 : 5'd14; cop_data_i = 32'hE0 + i;
      mid(); adv();
    end
    cop_req_i = 1'b0; rst = 1'b1;
    mid();
    check("t5_rst_we", w_enable_o, 1'b0);
    check("t5_rst_ready", cop_ready_o, 1'b0);
    adv();
    rst = 1'b0; wb_w_enable_i = 1'b0;
    mid();
    check("t5_pend", pend_mask_o, 32'h0);
    check("t5_we", w_enable_o, 1'b0);
    adv(); mid();
    check("t5_we2", w_enable_o, 1'b0);
    adv();

    // mixed traffic, model-checked only
    for (int i = 0; i < 40; i++) begin
      if (!last_stall) begin
        wb_w_enable_i = (i % 3) != 0;
        wb_w_addr_i   = 5'(i % 4);
        wb_w_data_i   = 32'h5000 + i;
      end
      cop_req_i  = ((i % 2) == 0) || ((i % 7) == 3);
      cop_addr_i = 5'((i * 3) % 6);
      cop_data_i = 32'h6000 + i;
      mid(); adv();
    end
    wb_w_enable_i = 1'b0; cop_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
